// File: rtl/bw_mac_pkg.sv
// Shared constants and types for the bw_mac16 multiply-accumulate stage.
package bw_mac_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int ACC_W_DEF = 40;
   localparam int ACC_W_MAX = 64;

   typedef enum logic {IDLE, ACCUM} state_t;

   // Saturation bounds are produced at ACC_W_MAX bits; callers truncate to their own ACC_W.
   function automatic logic [ACC_W_MAX-1:0] sat_pos_bound(input int w);
      return (ACC_W_MAX'(1) << (w - 1)) - ACC_W_MAX'(1);
   endfunction

   function automatic logic [ACC_W_MAX-1:0] sat_neg_bound(input int w);
      return ACC_W_MAX'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/BW_mul16.sv
// Baugh-Wooley signed WIDTH x WIDTH combinational multiplier.
module BW_mul16 #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0]   X,
   input  logic signed [WIDTH-1:0]   Y,
   output logic signed [2*WIDTH-1:0] P
);

   localparam int PW = 2 * WIDTH;
   // Complemented sign-row/column terms need 2^WIDTH + 2^(2*WIDTH-1) added back.
   localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) + (PW'(1) << (PW - 1));

   logic [PW-1:0]    sum;
   logic [WIDTH-1:0] row;
   logic             pp;

   always_comb begin
      sum = CORR;
      row = '0;
      pp  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp = X[i] & Y[j];
            if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp = ~pp;
            row[j] = pp;
         end
         sum = sum + (PW'(row) << i);
      end
   end

   assign P = sum;

endmodule

// File: rtl/bw_mac16.sv
// Signed dot-product MAC downstream of BW_mul16: one result per s_last-terminated vector.
// Optional macro BW_MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module bw_mac16
   import bw_mac_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WIDTH-1:0] s_x,
   input  logic signed [WIDTH-1:0] s_y,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [ACC_W-1:0] m_acc,
   output logic [15:0]             m_cnt,
   output logic                    m_ovf
);

   logic signed [2*WIDTH-1:0] prod_mul;
   logic signed [2*WIDTH-1:0] prod_p1;
   logic                      vld_p1;
   logic                      last_p1;
   logic                      stall;
   logic                      in_xfer;
   logic                      step;
   state_t                    state;
   state_t                    state_n;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   base;
   logic signed [ACC_W-1:0]   addend;
   logic signed [ACC_W-1:0]   sum_raw;
   logic signed [ACC_W-1:0]   sum;
   logic [15:0]               cnt_q;
   logic [15:0]               cnt_n;
   logic                      ovf_q;
   logic                      ovf_step;
   logic                      ovf_n;

`ifdef BW_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_POS = ACC_W'(sat_pos_bound(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_NEG = ACC_W'(sat_neg_bound(ACC_W));

   function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W-1:0] raw,
                                                      input logic ovf, input logic neg);
      if (!ovf) return raw;
      return neg ? SAT_NEG : SAT_POS;
   endfunction
`endif

   // A held result only blocks input once the next last term is waiting in S1.
   assign stall   = vld_p1 && last_p1 && m_valid && !m_ready;
   assign s_ready = !rst && !stall;
   assign in_xfer = s_valid && s_ready;
   assign step    = vld_p1 && !stall;

   BW_mul16 #(.WIDTH(WIDTH)) u_mul (
      .X (s_x),
      .Y (s_y),
      .P (prod_mul)
   );

   // ---- S1: registered product ----
   always_ff @(posedge clk) begin
      if (rst)         vld_p1 <= 1'b0;
      else if (!stall) vld_p1 <= in_xfer;
   end

   always_ff @(posedge clk) begin
      if (in_xfer) begin
         prod_p1 <= prod_mul;
         last_p1 <= s_last;
      end
   end

   // ---- S2: accumulate ----
   always_comb begin
      base     = (state == ACCUM) ? acc_q : '0;
      addend   = ACC_W'(prod_p1);
      sum_raw  = base + addend;
      ovf_step = (base[ACC_W-1] == addend[ACC_W-1]) && (sum_raw[ACC_W-1] != base[ACC_W-1]);
`ifdef BW_MAC_SAT_EN
      sum      = sat_sum(sum_raw, ovf_step, base[ACC_W-1]);
`else
      sum      = sum_raw;
`endif
      cnt_n    = ((state == ACCUM) ? cnt_q : 16'd0) + 16'd1;
      ovf_n    = ((state == ACCUM) && ovf_q) || ovf_step;
      state_n  = state;
      if (step) state_n = last_p1 ? IDLE : ACCUM;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (step && !last_p1) begin
         acc_q <= sum;
         cnt_q <= cnt_n;
         ovf_q <= ovf_n;
      end
   end

   // ---- Output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_acc   <= '0;
         m_cnt   <= '0;
         m_ovf   <= 1'b0;
      end else if (step && last_p1) begin
         m_valid <= 1'b1;
         m_acc   <= sum;
         m_cnt   <= cnt_n;
         m_ovf   <= ovf_n;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bw_mac16.sv
// Scoreboard bench for bw_mac16 at ACC_W=32 using directed, hand-computed vectors.
module tb_bw_mac16;

   localparam int WIDTH = 16;
   localparam int ACC_W = 32;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    s_valid = 1'b0;
   logic                    s_last = 1'b0;
   logic                    m_ready = 1'b1;
   logic signed [WIDTH-1:0] s_x = '0;
   logic signed [WIDTH-1:0] s_y = '0;
   logic                    s_ready;
   logic                    m_valid;
   logic                    m_ovf;
   logic signed [ACC_W-1:0] m_acc;
   logic [15:0]             m_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [ACC_W-1:0] acc;
      logic [15:0]      cnt;
      logic             ovf;
   } exp_t;

   exp_t sb[$];

   bw_mac16 #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_x     (s_x),
      .s_y     (s_y),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_acc   (m_acc),
      .m_cnt   (m_cnt),
      .m_ovf   (m_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic expect_result(input longint acc, input int cnt, input bit ovf);
      exp_t e;
      e.acc = ACC_W'(acc);
      e.cnt = 16'(cnt);
      e.ovf = ovf;
      sb.push_back(e);
   endtask

   task automatic send(input int x, input int y, input bit last);
      bit ok;
      ok = 1'b0;
      s_x = WIDTH'(x);
      s_y = WIDTH'(y);
      s_last = last;
      s_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got s_ready=0 for 200 cycles expected acceptance");
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   // Monitor: compares every output transfer against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got m_acc=%0d m_cnt=%0d expected no output", m_acc, m_cnt);
            end else begin
               e = sb.pop_front();
               chk("m_acc", longint'(m_acc), longint'($signed(e.acc)));
               chk("m_cnt", longint'(m_cnt), longint'(e.cnt));
               chk("m_ovf", longint'(m_ovf), longint'(e.ovf));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_acc", m_acc, 0);
      chk("rst_m_cnt", m_cnt, 0);
      chk("rst_m_ovf", m_ovf, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1);
      @(posedge clk);
      #1;

      // Single vector: 4 + 24 + 44 = 72
      m_ready = 1'b1;
      expect_result(72, 3, 0);
      send(2, 2, 0);
      send(12, 2, 0);
      send(22, 2, 1);
      chk("lat_after_edge_n", m_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_before_edge_n2", m_valid, 1);
      repeat (3) @(posedge clk);
      #1;

      // Signed single-term vectors, back-to-back
      expect_result(-196, 1, 0);
      expect_result(1073741824, 1, 0);
      send(-98, 2, 1);
      send(-32768, -32768, 1);
      repeat (4) @(posedge clk);
      #1;

      // Back-pressure: three 2-term vectors of (1,1),(1,1)
      m_ready = 1'b0;
      expect_result(2, 2, 0);
      expect_result(2, 2, 0);
      expect_result(2, 2, 0);
      fork
         begin
            for (int v = 0; v < 3; v++) begin
               send(1, 1, 0);
               send(1, 1, 1);
            end
         end
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("bp_s_ready_low", s_ready, 0);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_acc", m_acc, 2);
            @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk);
      #1;

      // Overflow at ACC_W=32: 3 * 2^30
`ifdef BW_MAC_SAT_EN
      expect_result(32'sh7FFFFFFF, 3, 1);
`else
      expect_result(-1073741824, 3, 1);
`endif
      send(-32768, -32768, 0);
      send(-32768, -32768, 0);
      send(-32768, -32768, 1);
      repeat (4) @(posedge clk);
      #1;

      // Reset mid-vector discards the partial sum
      send(5, 5, 0);
      send(5, 5, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_result(9, 1, 0);
      send(3, 3, 1);

      for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
